// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the memory port arbiter
package pipeline_pkg;

  localparam int         XLEN   = 32;
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection between fetch and data requests
module mem_arb_pick #(
  parameter int STARVE_LIMIT = 2,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic             halt,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             pick_i,
  output logic             pick_d
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Data normally wins; a waiting fetch takes over once the data side has used its quota.
  assign pick_d = !halt && d_req && (!if_req || (starve_cnt < LIMIT));
  assign pick_i = !halt && if_req && !pick_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            halt,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  output logic            stall_fetch,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             pick_i;
  logic             pick_d;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .halt       (halt),
    .starve_cnt (starve_cnt),
    .pick_i     (pick_i),
    .pick_d     (pick_d)
  );

  assign if_gnt      = (state == IDLE) && pick_i;
  assign d_gnt       = (state == IDLE) && pick_d;
  assign stall_fetch = if_req && !if_gnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_gnt) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
          end else if (if_gnt) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= BE_ALL;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            d_rdata  <= mem_rdata;
            d_rvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counts data grants that overtook a waiting fetch; saturates at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && if_req && (starve_cnt != CNT_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
